// File: rtl/reg_bank_wb_if.sv
// Core write-back and DMA register-write handshake bundle for reg_bank_wb.
// Data buses are numbered bit 0 = MSB.
interface reg_bank_wb_if;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    // Core write-back port
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [0:DW-1] wr_data;
    logic          core_stall;

    // DMA single-entry write port
    logic          dma_valid;
    logic [AW-1:0] dma_addr;
    logic [0:DW-1] dma_data;
    logic          dma_ready;
    logic          dma_done;

    modport master (
        output wr_en, wr_addr, wr_data, dma_valid, dma_addr, dma_data,
        input  core_stall, dma_ready, dma_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, dma_valid, dma_addr, dma_data,
        output core_stall, dma_ready, dma_done
    );
endinterface

// File: rtl/reg_bank_wb.sv
// 32x32 register bank with core write-back port and a one-entry DMA write buffer
// that steals idle write slots, forcing a core stall after 8 blocked cycles.
// Optional same-cycle write bypass on the named outputs: define REG_BANK_FWD_EN.
module reg_bank_wb #(
    localparam int unsigned AW   = 5,
    localparam int unsigned DW   = 32,
    localparam int unsigned NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    reg_bank_wb_if.slave  bus,
    output logic [0:DW-1] zero,
    output logic [0:DW-1] v0,
    output logic [0:DW-1] v1,
    output logic [0:DW-1] a0,
    output logic [0:DW-1] a1,
    output logic [0:DW-1] a2,
    output logic [0:DW-1] a3,
    output logic [0:DW-1] t0,
    output logic [0:DW-1] t1,
    output logic [0:DW-1] t2,
    output logic [0:DW-1] t3,
    output logic [0:DW-1] t4,
    output logic [0:DW-1] t5,
    output logic [0:DW-1] t6,
    output logic [0:DW-1] t7,
    output logic [0:DW-1] s0,
    output logic [0:DW-1] s1,
    output logic [0:DW-1] s2,
    output logic [0:DW-1] s3,
    output logic [0:DW-1] s4,
    output logic [0:DW-1] s5,
    output logic [0:DW-1] s6,
    output logic [0:DW-1] s7,
    output logic [0:DW-1] t8,
    output logic [0:DW-1] t9,
    output logic [0:DW-1] gp,
    output logic [0:DW-1] sp,
    output logic [0:DW-1] fp,
    output logic [0:DW-1] ra
);
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic [AW-1:0] buf_addr;
    logic [0:DW-1] buf_data;
    logic          dma_done_q;
    logic [0:DW-1] regs   [NREG];
    logic [0:DW-1] rd_val [NREG];
    logic          core_we_c;
    logic          commit_c;

    // Handshake decode straight from state
    assign bus.dma_ready  = (state == IDLE);
    assign bus.core_stall = (state == FORCE);
    assign bus.dma_done   = dma_done_q;

    // Core and DMA never write on the same edge: PEND commits only when the core is idle
    assign core_we_c = bus.wr_en && (state != FORCE);
    assign commit_c  = (state == FORCE) || ((state == PEND) && !bus.wr_en);

    // DMA buffer FSM with starvation counter and commit pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            buf_addr   <= '0;
            buf_data   <= '0;
            dma_done_q <= 1'b0;
        end else begin
            dma_done_q <= commit_c;
            unique case (state)
                IDLE: begin
                    if (bus.dma_valid) begin
                        buf_addr   <= bus.dma_addr;
                        buf_data   <= bus.dma_data;
                        starve_cnt <= '0;
                        state      <= PEND;
                    end
                end
                PEND: begin
                    if (!bus.wr_en) begin
                        state <= IDLE;
                    end else if (starve_cnt == CW'(7)) begin
                        starve_cnt <= '0;
                        state      <= FORCE;
                    end else begin
                        starve_cnt <= starve_cnt + CW'(1);
                    end
                end
                FORCE: begin
                    starve_cnt <= '0;
                    state      <= IDLE;
                end
                default: begin
                    starve_cnt <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Register file; index 0 is never written so it reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (core_we_c && (bus.wr_addr != '0)) begin
                regs[bus.wr_addr] <= bus.wr_data;
            end
            if (commit_c && (buf_addr != '0)) begin
                regs[buf_addr] <= buf_data;
            end
        end
    end

    // Read view, optionally bypassing the write landing this cycle
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            rd_val[i] = regs[i];
`ifdef REG_BANK_FWD_EN
            if (!rst && (i != 0)) begin
                if (core_we_c && (bus.wr_addr == AW'(i))) begin
                    rd_val[i] = bus.wr_data;
                end else if (commit_c && (buf_addr == AW'(i))) begin
                    rd_val[i] = buf_data;
                end
            end
`endif
        end
    end

    assign zero = rd_val[0];
    assign v0   = rd_val[2];
    assign v1   = rd_val[3];
    assign a0   = rd_val[4];
    assign a1   = rd_val[5];
    assign a2   = rd_val[6];
    assign a3   = rd_val[7];
    assign t0   = rd_val[8];
    assign t1   = rd_val[9];
    assign t2   = rd_val[10];
    assign t3   = rd_val[11];
    assign t4   = rd_val[12];
    assign t5   = rd_val[13];
    assign t6   = rd_val[14];
    assign t7   = rd_val[15];
    assign s0   = rd_val[16];
    assign s1   = rd_val[17];
    assign s2   = rd_val[18];
    assign s3   = rd_val[19];
    assign s4   = rd_val[20];
    assign s5   = rd_val[21];
    assign s6   = rd_val[22];
    assign s7   = rd_val[23];
    assign t8   = rd_val[24];
    assign t9   = rd_val[25];
    assign gp   = rd_val[28];
    assign sp   = rd_val[29];
    assign fp   = rd_val[30];
    assign ra   = rd_val[31];
endmodule
